mem_port_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 11 +
 rtl/mem_port_arbiter_if.sv | 34 +++
 rtl/mem_arb_stall_gen.sv | 23 ++
 rtl/mem_port_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the unified-memory port arbiter.
package mem_arb_pkg;

  localparam int DEF_AW      = 32;
  localparam int DEF_DW      = 32;
  localparam int DEF_TIMEOUT = 255;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory handshake bundle; slave = arbiter view, master = requesters + memory.
interface mem_port_arbiter_if import mem_arb_pkg::*; #(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ack;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ack;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output if_rdata, if_ack, d_rdata, d_ack, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_ack, d_rdata, d_ack, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arb_stall_gen.sv
// Pipeline freeze logic: every stage enable drops while a memory request is unacknowledged.
module mem_arb_stall_gen (
  input  logic rst,
  input  logic if_req,
  input  logic if_ack,
  input  logic d_req,
  input  logic d_ack,
  output logic pc_write_en,
  output logic ifid_en,
  output logic idex_en,
  output logic exmem_en,
  output logic memwb_en
);
  logic advance;

  // The ack cycle itself lets the pipeline advance, so the requester sees its data once.
  assign advance     = ~rst & ~((if_req & ~if_ack) | (d_req & ~d_ack));
  assign pc_write_en = advance;
  assign ifid_en     = advance;
  assign idex_en     = advance;
  assign exmem_en    = advance;
  assign memwb_en    = advance;
endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for one single-ported memory, data has fixed priority.
// Optional ISSUE watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter import mem_arb_pkg::*; #(
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus,
  output logic                pc_write_en,
  output logic                ifid_en,
  output logic                idex_en,
  output logic                exmem_en,
  output logic                memwb_en,
  output logic                err
);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  typedef logic [CNT_W-1:0] cnt_t;

  state_t        state;
  owner_t        owner;
  logic          timeout_hit;
  logic          finish;
  logic [DW-1:0] resp_data;

`ifdef ARB_TIMEOUT_EN
  cnt_t issue_cnt;

  // The final waiting ISSUE cycle is the one where the count equals TIMEOUT-1.
  assign timeout_hit = (state == ISSUE) && !bus.mem_ready && (issue_cnt == cnt_t'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt <= '0;
      err       <= 1'b0;
    end else begin
      if (state == IDLE && (bus.d_req || bus.if_req))
        issue_cnt <= '0;
      else if (state == ISSUE)
        issue_cnt <= issue_cnt + cnt_t'(1);
      if (timeout_hit)
        err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  assign finish    = (state == ISSUE) && (bus.mem_ready || timeout_hit);
  assign resp_data = bus.mem_ready ? bus.mem_rdata : {DW{1'b0}};

  // NOTE: state and outputs are registers, so every assignment here is non-blocking;
  // blocking ones would make later reads in this block see this cycle's new value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      owner         <= OWN_NONE;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= {AW{1'b0}};
      bus.mem_wdata <= {DW{1'b0}};
      bus.if_rdata  <= {DW{1'b0}};
      bus.d_rdata   <= {DW{1'b0}};
      bus.if_ack    <= 1'b0;
      bus.d_ack     <= 1'b0;
    end else begin
      bus.if_ack <= 1'b0;
      bus.d_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.d_req) begin
            owner         <= OWN_D;
            bus.mem_addr  <= bus.d_addr;
            bus.mem_we    <= bus.d_we;
            bus.mem_wdata <= bus.d_wdata;
            bus.mem_req   <= 1'b1;
            state         <= ISSUE;
          end else if (bus.if_req) begin
            owner         <= OWN_IF;
            bus.mem_addr  <= bus.if_addr;
            bus.mem_we    <= 1'b0;
            bus.mem_req   <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (finish) begin
            if (!bus.mem_we) begin
              if (owner == OWN_IF) bus.if_rdata <= resp_data;
              if (owner == OWN_D)  bus.d_rdata  <= resp_data;
            end
            bus.if_ack  <= (owner == OWN_IF);
            bus.d_ack   <= (owner == OWN_D);
            bus.mem_req <= 1'b0;
            bus.mem_we  <= 1'b0;
            state       <= RESP;
          end
        end
        RESP: begin
          owner <= OWN_NONE;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  mem_arb_stall_gen u_stall (
    .rst         (rst),
    .if_req      (bus.if_req),
    .if_ack      (bus.if_ack),
    .d_req       (bus.d_req),
    .d_ack       (bus.d_ack),
    .pc_write_en (pc_write_en),
    .ifid_en     (ifid_en),
    .idex_en     (idex_en),
    .exmem_en    (exmem_en),
    .memwb_en    (memwb_en)
  );
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, conflict, store, reset abort, back-to-back, watchdog.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst;
  logic pc_write_en, ifid_en, idex_en, exmem_en, memwb_en, err;
  int   errors = 0;
  int   checks = 0;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .pc_write_en (pc_write_en),
    .ifid_en     (ifid_en),
    .idex_en     (idex_en),
    .exmem_en    (exmem_en),
    .memwb_en    (memwb_en),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst           = 1'b1;
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.mem_rdata = '0;
    bus.mem_ready = 1'b0;
    tick();
    chk1("rst_pc_en", pc_write_en, 1'b0);
    chk1("rst_memwb_en", memwb_en, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    chk1("rst_mem_req", bus.mem_req, 1'b0);
    chk1("rst_mem_we", bus.mem_we, 1'b0);
    chk1("rst_if_ack", bus.if_ack, 1'b0);
    chk1("rst_d_ack", bus.d_ack, 1'b0);
    chk32("rst_mem_addr", bus.mem_addr, 32'h0);
    chk32("rst_if_rdata", bus.if_rdata, 32'h0);
    chk32("rst_d_rdata", bus.d_rdata, 32'h0);
    chk1("rst_err", err, 1'b0);
    chk1("idle_en", ifid_en, 1'b1);

    // Single fetch, zero wait
    bus.if_req = 1'b1; bus.if_addr = 32'h40;
    #1;
    chk1("f1_stall_req", pc_write_en, 1'b0);
    tick();
    chk1("f1_mem_req", bus.mem_req, 1'b1);
    chk32("f1_mem_addr", bus.mem_addr, 32'h40);
    chk1("f1_mem_we", bus.mem_we, 1'b0);
    chk1("f1_no_ack", bus.if_ack, 1'b0);
    chk1("f1_stall_issue", idex_en, 1'b0);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h8C220004;
    tick();
    chk1("f1_if_ack", bus.if_ack, 1'b1);
    chk32("f1_if_rdata", bus.if_rdata, 32'h8C220004);
    chk1("f1_mem_req_drop", bus.mem_req, 1'b0);
    chk1("f1_en_ack", pc_write_en, 1'b1);
    bus.if_req = 1'b0; bus.mem_ready = 1'b0; bus.mem_rdata = 32'hFFFF_FFFF;
    tick();
    chk1("f1_ack_pulse", bus.if_ack, 1'b0);
    chk32("f1_rdata_hold", bus.if_rdata, 32'h8C220004);

    // Conflict: data read wins, fetch follows
    bus.if_req = 1'b1; bus.if_addr = 32'h44;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h100;
    tick();
    chk32("c_d_addr", bus.mem_addr, 32'h100);
    chk1("c_d_mem_req", bus.mem_req, 1'b1);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h1234;
    tick();
    chk1("c_d_ack", bus.d_ack, 1'b1);
    chk1("c_if_not_ack", bus.if_ack, 1'b0);
    chk32("c_d_rdata", bus.d_rdata, 32'h1234);
    chk1("c_stall_if_pending", ifid_en, 1'b0);
    bus.d_req = 1'b0; bus.mem_ready = 1'b0;
    tick();
    chk1("c_resp_idle_req", bus.mem_req, 1'b0);
    chk1("c_d_ack_pulse", bus.d_ack, 1'b0);
    tick();
    chk32("c_if_addr", bus.mem_addr, 32'h44);
    chk1("c_if_mem_req", bus.mem_req, 1'b1);
    chk1("c_stall_if", idex_en, 1'b0);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'hCAFE0001;
    tick();
    chk1("c_if_ack", bus.if_ack, 1'b1);
    chk32("c_if_rdata", bus.if_rdata, 32'hCAFE0001);
    chk32("c_d_rdata_hold", bus.d_rdata, 32'h1234);
    chk1("c_en_ack", exmem_en, 1'b1);
    bus.if_req = 1'b0; bus.mem_ready = 1'b0;
    tick();

    // Store with three wait cycles
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h200; bus.d_wdata = 32'hDEADBEEF;
    bus.mem_rdata = 32'h5555_5555;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk1("s_mem_req", bus.mem_req, 1'b1);
      chk1("s_mem_we", bus.mem_we, 1'b1);
      chk32("s_mem_addr", bus.mem_addr, 32'h200);
      chk32("s_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
      chk1("s_no_ack", bus.d_ack, 1'b0);
      if (i == 3) bus.mem_ready = 1'b1;
    end
    tick();
    chk1("s_d_ack", bus.d_ack, 1'b1);
    chk1("s_mem_we_drop", bus.mem_we, 1'b0);
    chk32("s_d_rdata_kept", bus.d_rdata, 32'h1234);
    chk32("s_if_rdata_kept", bus.if_rdata, 32'hCAFE0001);
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.mem_ready = 1'b0;
    tick();
    chk1("s_ack_pulse", bus.d_ack, 1'b0);

    // Reset while in ISSUE
    bus.if_req = 1'b1; bus.if_addr = 32'h80;
    tick();
    chk1("r_mem_req", bus.mem_req, 1'b1);
    rst = 1'b1;
    #1;
    chk1("r_en_in_rst", memwb_en, 1'b0);
    tick();
    chk1("r_mem_req_drop", bus.mem_req, 1'b0);
    chk1("r_no_ack", bus.if_ack, 1'b0);
    rst = 1'b0; bus.if_req = 1'b0; bus.mem_ready = 1'b1;
    tick();
    chk1("r_idle_ignores_ready", bus.mem_req, 1'b0);
    chk1("r_still_no_ack", bus.if_ack, 1'b0);
    bus.mem_ready = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 32'h84;
    tick();
    chk32("r_new_addr", bus.mem_addr, 32'h84);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h1111_2222;
    tick();
    chk1("r_new_ack", bus.if_ack, 1'b1);
    chk32("r_new_rdata", bus.if_rdata, 32'h1111_2222);
    bus.if_req = 1'b0; bus.mem_ready = 1'b0;
    tick();

    // Back-to-back fetches, request held high with a new address after each ack
    bus.if_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.if_addr = 32'h400 + 32'(k * 4);
      tick();
      chk1("b_grant_req", bus.mem_req, 1'b1);
      chk32("b_grant_addr", bus.mem_addr, 32'h400 + 32'(k * 4));
      chk1("b_grant_no_ack", bus.if_ack, 1'b0);
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'hA000_0000 + 32'(k);
      tick();
      chk1("b_ack", bus.if_ack, 1'b1);
      chk32("b_rdata", bus.if_rdata, 32'hA000_0000 + 32'(k));
      bus.mem_ready = 1'b0;
      if (k == 2) bus.if_req = 1'b0;
      tick();
      chk1("b_resp_no_dup", bus.if_ack, 1'b0);
      chk1("b_resp_no_req", bus.mem_req, 1'b0);
    end
    tick();
    chk1("b_final_idle", bus.mem_req, 1'b0);
    chk1("b_final_no_ack", bus.if_ack, 1'b0);

`ifdef ARB_TIMEOUT_EN
    // Watchdog: memory never answers
    bus.if_req = 1'b1; bus.if_addr = 32'h300;
    tick();
    for (int w = 0; w < 3; w++) begin
      tick();
      chk1("t_wait_err", err, 1'b0);
      chk1("t_wait_req", bus.mem_req, 1'b1);
    end
    tick();
    chk1("t_err_set", err, 1'b1);
    chk1("t_ack", bus.if_ack, 1'b1);
    chk32("t_rdata_zero", bus.if_rdata, 32'h0);
    bus.if_req = 1'b0;
    tick();
    tick();
    chk1("t_err_sticky", err, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk1("t_err_cleared", err, 1'b0);
`else
    chk1("no_timeout_err", err, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
